// File: rtl/myproject_mac_accum_requant.sv
// Dot-product accumulator with round/shift requantization and a held output.
// Optional saturation of the narrowed result: define MYPROJECT_ACC_SAT_EN.
//
// Ports:
//   ap_clk, ap_rst         clock, synchronous active-high reset
//   in_data/valid/last     signed product stream, in_last marks final term
//   in_ready               beat accepted when in_valid & in_ready
//   out_data/nterms/sat    requantized group result, term count, clip flag
//   out_valid/out_ready    result handshake, output held under backpressure
module myproject_mac_accum_requant #(
    parameter int PROD_WIDTH = 36,
    parameter int ACC_WIDTH  = 44,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAC_SHIFT = 10,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [PROD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic [CNT_WIDTH-1:0]  out_nterms,
    output logic                  out_sat,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic {ACCUM, HOLD} state_t;

    // width of the rounded, shifted sum (one spare bit so +half never overflows)
    localparam int RW = ACC_WIDTH - FRAC_SHIFT + 1;

    state_t                       state;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic        [CNT_WIDTH-1:0]  cnt;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic        [CNT_WIDTH-1:0]  cnt_nxt;
    logic signed [RW-1:0]         r;
    logic        [OUT_WIDTH-1:0]  q;
    logic                         q_sat;
    logic                         take;
    logic                         drain;

    assign out_valid = (state == HOLD);
    assign in_ready  = !ap_rst && (!out_valid || out_ready);
    assign take      = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    assign prod = in_data;
    assign sum  = acc + ACC_WIDTH'(prod);

    // saturating count; also equals the term count of a group ending now
    assign cnt_nxt = (&cnt) ? cnt : cnt + 1'b1;

    // (sum + half) >>> shift == floor(sum >>> shift) + first dropped bit
    assign r = {sum[ACC_WIDTH-1], sum[ACC_WIDTH-1:FRAC_SHIFT]}
             + {{(RW-1){1'b0}}, sum[FRAC_SHIFT-1]};

`ifdef MYPROJECT_ACC_SAT_EN
    localparam logic signed [RW-1:0] RMAX =
        RW'((longint'(1) <<< (OUT_WIDTH-1)) - 1);
    localparam logic signed [RW-1:0] RMIN = ~RMAX;

    always_comb begin
        q     = r[OUT_WIDTH-1:0];
        q_sat = 1'b0;
        if (r > RMAX) begin
            q     = RMAX[OUT_WIDTH-1:0];
            q_sat = 1'b1;
        end else if (r < RMIN) begin
            q     = RMIN[OUT_WIDTH-1:0];
            q_sat = 1'b1;
        end
    end
`else
    assign q     = r[OUT_WIDTH-1:0];
    assign q_sat = 1'b0;
`endif

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state      <= ACCUM;
            acc        <= '0;
            cnt        <= '0;
            out_data   <= '0;
            out_nterms <= '0;
            out_sat    <= 1'b0;
        end else begin
            // a consumed result frees the output; a same-cycle last beat reloads it
            if (drain) begin
                state <= ACCUM;
            end
            if (take) begin
                if (in_last) begin
                    acc        <= '0;
                    cnt        <= '0;
                    out_data   <= q;
                    out_nterms <= cnt_nxt;
                    out_sat    <= q_sat;
                    state      <= HOLD;
                end else begin
                    acc <= sum;
                    cnt <= cnt_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_myproject_mac_accum_requant.sv
// Self-checking bench: vector table, multi-cycle corner sequences,
// and randomized traffic scored against a group-level arithmetic model.
module tb_myproject_mac_accum_requant;

    localparam int PW = 36;
    localparam int AW = 44;
    localparam int OW = 16;
    localparam int FS = 10;
    localparam int CW = 8;
`ifdef MYPROJECT_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic [PW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [OW-1:0] out_data;
    logic [CW-1:0] out_nterms;
    logic          out_sat;
    logic          out_valid;
    logic          out_ready;

    myproject_mac_accum_requant dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_nterms (out_nterms),
        .out_sat    (out_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        longint d;
        longint n;
        longint s;
    } res_t;

    typedef struct {
        int     n;
        longint t[4];
        longint d;
        longint nt;
        longint s;
    } vec_t;

    int     npass = 0;
    int     ntot  = 0;
    longint grp[$];
    res_t   expq[$];
    vec_t   tbl[12];

    task automatic chk(input string nm, input longint act, input longint exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // group result from the list of terms, by plain integer arithmetic
    function automatic res_t model(input longint total, input int n);
        res_t   e;
        longint m, s, num, den, r, ow;
        m = longint'(1) <<< AW;
        s = total % m;
        if (s < 0) s += m;
        if (s >= m / 2) s -= m;
        den = longint'(1) <<< FS;
        num = s + den / 2;
        r = num / den;
        if ((num % den) != 0 && num < 0) r = r - 1;
        ow = longint'(1) <<< OW;
        e.n = (n > (1 << CW) - 1) ? (1 << CW) - 1 : n;
        e.s = 0;
        if (SAT) begin
            e.d = r;
            if (r > ow / 2 - 1) begin e.d = ow / 2 - 1; e.s = 1; end
            if (r < -(ow / 2)) begin e.d = -(ow / 2); e.s = 1; end
        end else begin
            e.d = r % ow;
            if (e.d < 0) e.d += ow;
            if (e.d >= ow / 2) e.d -= ow;
        end
        return e;
    endfunction

    // one clock: score handshakes seen before the edge, return at edge+1
    task automatic cycle(output bit fired);
        res_t   e;
        longint total;
        #2;
        fired = in_valid && in_ready;
        if (ap_rst) begin
            grp.delete();
            expq.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("sb_pending", longint'(expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("sb_data", $signed(out_data), e.d);
                    chk("sb_nterms", out_nterms, e.n);
                    chk("sb_sat", out_sat, e.s);
                end
            end
            if (fired) begin
                grp.push_back(longint'($signed(in_data)));
                if (in_last) begin
                    total = 0;
                    foreach (grp[i]) total += grp[i];
                    expq.push_back(model(total, grp.size()));
                    grp.delete();
                end
            end
        end
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        bit          f;
        int          sent;
        int          cyc;
        int          groups;
        int          idx;
        int          len;
        int          bw;
        longint      v;
        logic [63:0] raw;

        tbl[0]  = '{3, '{1024, 2048, 512, 0}, 4, 3, 0};
        tbl[1]  = '{1, '{-1536, 0, 0, 0}, -1, 1, 0};
        tbl[2]  = '{1, '{40000000, 0, 0, 0}, SAT ? 32767 : -26473, 1, SAT};
        tbl[3]  = '{1, '{-512, 0, 0, 0}, 0, 1, 0};
        tbl[4]  = '{1, '{-513, 0, 0, 0}, -1, 1, 0};
        tbl[5]  = '{1, '{511, 0, 0, 0}, 0, 1, 0};
        tbl[6]  = '{1, '{512, 0, 0, 0}, 1, 1, 0};
        tbl[7]  = '{1, '{33553408, 0, 0, 0}, 32767, 1, 0};
        tbl[8]  = '{1, '{33553920, 0, 0, 0}, SAT ? 32767 : -32768, 1, SAT};
        tbl[9]  = '{1, '{-33554432, 0, 0, 0}, -32768, 1, 0};
        tbl[10] = '{1, '{-33554945, 0, 0, 0}, SAT ? -32768 : 32767, 1, SAT};
        tbl[11] = '{3, '{-40000000, 1000, 24, 0}, SAT ? -32768 : 26475, 3, SAT};

        ap_rst    = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        cycle(f);
        cycle(f);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_nterms", out_nterms, 0);
        chk("rst_out_sat", out_sat, 0);
        ap_rst = 1'b0;
        cycle(f);

        foreach (tbl[k]) begin
            for (int j = 0; j < tbl[k].n; j++) begin
                in_valid = 1'b1;
                in_data  = PW'(tbl[k].t[j]);
                in_last  = (j == tbl[k].n - 1);
                cycle(f);
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            chk($sformatf("vec%0d_valid", k), out_valid, 1);
            chk($sformatf("vec%0d_data", k), $signed(out_data), tbl[k].d);
            chk($sformatf("vec%0d_nterms", k), out_nterms, tbl[k].nt);
            chk($sformatf("vec%0d_sat", k), out_sat, tbl[k].s);
        end
        cycle(f);

        // backpressure: result held five cycles, then back-to-back reload
        in_valid = 1'b1;
        in_data  = PW'(3072);
        in_last  = 1'b1;
        cycle(f);
        out_ready = 1'b0;
        in_data   = PW'(2048);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_data", $signed(out_data), 3);
            cycle(f);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        cycle(f);
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_data", $signed(out_data), 2);
        chk("bp_next_nterms", out_nterms, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        cycle(f);

        // reset mid-group drops the partial sum
        in_valid = 1'b1;
        in_data  = PW'(4096);
        in_last  = 1'b0;
        cycle(f);
        cycle(f);
        in_valid = 1'b0;
        ap_rst   = 1'b1;
        cycle(f);
        ap_rst = 1'b0;
        chk("mrst_valid", out_valid, 0);
        in_valid = 1'b1;
        in_data  = PW'(1024);
        in_last  = 1'b1;
        cycle(f);
        chk("mrst_res_valid", out_valid, 1);
        chk("mrst_data", $signed(out_data), 1);
        chk("mrst_nterms", out_nterms, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        cycle(f);
        chk("mrst_no_extra", out_valid, 0);

        // 300 zero beats with bubbles: counter saturates
        sent = 0;
        cyc  = 0;
        while (sent < 300 && cyc < 3000) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = '0;
            in_last  = (sent == 299);
            cycle(f);
            if (f) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bub_sent", sent, 300);
        chk("bub_valid", out_valid, 1);
        chk("bub_data", $signed(out_data), 0);
        chk("bub_nterms", out_nterms, 255);
        cycle(f);

        // random groups, random gaps and backpressure
        groups = 0;
        idx    = 0;
        len    = $urandom_range(1, 6);
        cyc    = 0;
        while (groups < 60 && cyc < 4000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       bw = 12;
                1:       bw = 20;
                2:       bw = 27;
                default: bw = 36;
            endcase
            raw     = {$urandom(), $urandom()};
            v       = $signed(raw) >>> (64 - bw);
            in_data = PW'(v);
            in_last = (idx == len - 1);
            cycle(f);
            if (f) begin
                idx++;
                if (idx == len) begin
                    idx = 0;
                    len = $urandom_range(1, 6);
                    groups++;
                end
            end
            cyc++;
        end
        chk("rnd_groups", groups, 60);

        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        repeat (3) cycle(f);
        chk("drain_empty", expq.size(), 0);
        chk("drain_valid", out_valid, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
